// File: rtl/multiplicador_param.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Magnitudes are multiplied and the sign is applied once in the final adjust cycle.
module multiplicador_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sinal,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   RESFINAL
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    AJUSTE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 sign_q, sign_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  // Absolute value; the most negative input maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    if (s && v[WIDTH-1]) begin
      magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  logic [WIDTH:0]   sum_s;
  logic [2*WIDTH:0] step_s;

  // Next-state, iteration and output logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    sum_s   = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    step_s  = acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = magnitude(A, sinal);
          acc_d   = {{(WIDTH+1){1'b0}}, magnitude(B, sinal)};
          sign_d  = sinal & (A[WIDTH-1] ^ B[WIDTH-1]);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end else begin
          busy_d  = 1'b0;
        end
      end
      CALC: begin
        // Upper WIDTH+1 bits take the partial sum; the multiplier drains out of the low bits.
        if (acc_q[0]) begin
          step_s = {sum_s, acc_q[WIDTH-1:0]};
        end else begin
          step_s = acc_q;
        end
        acc_d  = {1'b0, step_s[2*WIDTH:1]};
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        busy_d = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = AJUSTE;
        end else begin
          state_d = CALC;
        end
      end
      AJUSTE: begin
        if (sign_q) begin
          res_d = ~acc_q[2*WIDTH-1:0] + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
          res_d = acc_q[2*WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign RESFINAL = res_q;

endmodule

// File: tb/tb_multiplicador_param.sv
// Randomised and directed checks of multiplicador_param at WIDTH=8 and WIDTH=16
// against an arithmetic reference product.
module tb_multiplicador_param;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start8 = 1'b0, s8 = 1'b0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0;
  logic        busy8, done8;
  logic [15:0] res8;
  logic        start16 = 1'b0, s16 = 1'b0;
  logic [15:0] a16 = 16'd0, b16 = 16'd0;
  logic        busy16, done16;
  logic [31:0] res16;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  multiplicador_param #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .sinal(s8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .RESFINAL(res8)
  );

  multiplicador_param #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .sinal(s16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .RESFINAL(res16)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain integer product of the operands as signed or unsigned values, wrapped to 2*w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    longint av, bv, p, mask;
    mask = (64'sd1 <<< w) - 64'sd1;
    av = longint'(a) & mask;
    bv = longint'(b) & mask;
    if (s && av >= (64'sd1 <<< (w - 1))) av = av - (64'sd1 <<< w);
    if (s && bv >= (64'sd1 <<< (w - 1))) bv = bv - (64'sd1 <<< w);
    p = (av * bv) & ((64'sd1 <<< (2 * w)) - 64'sd1);
    return p[31:0];
  endfunction

  // One full operation; caller is at a negedge. Checks latency, busy length, product, done width.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic s,
                        input string tag);
    int edges, busy_n;
    bit seen;
    logic [31:0] exp;
    exp = ref_mul(w, a, b, s);
    if (w == 16) begin a16 = a; b16 = b; s16 = s; start16 = 1'b1; end
    else begin a8 = a[7:0]; b8 = b[7:0]; s8 = s; start8 = 1'b1; end
    @(posedge clock);
    @(negedge clock);
    start8 = 1'b0; start16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s;
    a16 = 16'($urandom); b16 = 16'($urandom); s16 = ~s;
    busy_n = ((w == 16) ? busy16 : busy8) ? 1 : 0;
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if ((w == 16) ? busy16 : busy8) busy_n++;
      if ((w == 16) ? done16 : done8) seen = 1'b1;
    end
    check_eq({tag, " latency"}, 64'(edges), 64'(w + 1));
    check_eq({tag, " busy_cycles"}, 64'(busy_n), 64'(w + 1));
    check_eq({tag, " result"}, 64'((w == 16) ? res16 : {16'd0, res8}), 64'(exp));
    @(posedge clock);
    @(negedge clock);
    check_eq({tag, " done_pulse"}, 64'((w == 16) ? done16 : done8), 64'd0);
  endtask

  initial begin
    int edges, e1, e2, dcnt;
    logic [15:0] ra, rb;
    logic rs;

    #2;
    check_eq("rst busy8", 64'(busy8), 64'd0);
    check_eq("rst done8", 64'(done8), 64'd0);
    check_eq("rst res8", 64'(res8), 64'd0);
    check_eq("rst res16", 64'(res16), 64'(32'd0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_op(8, 16'h00FD, 16'h0007, 1'b1, "neg3x7");
    check_eq("neg3x7 value", 64'(res8), 64'(16'hFFEB));
    run_op(8, 16'h0080, 16'h0080, 1'b1, "min_x_min");
    check_eq("min_x_min value", 64'(res8), 64'(16'h4000));
    run_op(8, 16'h00FF, 16'h00FF, 1'b0, "ff_x_ff_u");
    check_eq("ff_x_ff_u value", 64'(res8), 64'(16'hFE01));
    run_op(8, 16'h0080, 16'h007F, 1'b1, "min_x_max");
    check_eq("min_x_max value", 64'(res8), 64'(16'hC080));
    run_op(8, 16'h0000, 16'h005A, 1'b1, "zero_a");
    run_op(8, 16'h00C3, 16'h0000, 1'b0, "zero_b");

    // Start pulsed mid-operation with new operands must be ignored.
    a8 = 8'd5; b8 = 8'd6; s8 = 1'b0; start8 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start8 = 1'b0;
    edges = 0;
    while (!done8 && edges < 40) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (edges == 3) begin a8 = 8'h11; b8 = 8'h22; start8 = 1'b1; end
      else start8 = 1'b0;
    end
    check_eq("midstart latency", 64'(edges), 64'd9);
    check_eq("midstart result", 64'(res8), 64'(16'h001E));
    dcnt = 0;
    repeat (12) begin
      @(posedge clock);
      @(negedge clock);
      if (done8 || busy8) dcnt++;
    end
    check_eq("midstart ignored", 64'(dcnt), 64'd0);

    // Start held through done: second op accepted right after the done cycle.
    a8 = 8'd5; b8 = 8'd6; s8 = 1'b0; start8 = 1'b1;
    edges = 0; e1 = 0; e2 = 0; dcnt = 0;
    while (dcnt < 2 && edges < 60) begin
      @(posedge clock);
      @(negedge clock);
      if (done8) begin
        dcnt++;
        if (dcnt == 1) begin
          e1 = edges;
          check_eq("held first", 64'(res8), 64'(16'd30));
          a8 = 8'd3; b8 = 8'd4;
        end else begin
          e2 = edges;
          check_eq("held second", 64'(res8), 64'(16'd12));
          start8 = 1'b0;
        end
      end
      edges++;
    end
    check_eq("held e1", 64'(e1), 64'd9);
    check_eq("held e2", 64'(e2), 64'd19);
    @(negedge clock);
    start8 = 1'b0;
    repeat (12) @(negedge clock);

    // Asynchronous abort in the middle of an operation.
    a8 = 8'd5; b8 = 8'd6; s8 = 1'b0; start8 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start8 = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check_eq("abort busy", 64'(busy8), 64'd0);
    check_eq("abort done", 64'(done8), 64'd0);
    check_eq("abort res", 64'(res8), 64'd0);
    dcnt = 0;
    repeat (12) begin
      @(negedge clock);
      if (done8) dcnt++;
    end
    check_eq("abort no_done", 64'(dcnt), 64'd0);
    reset = 1'b1;
    run_op(8, 16'h00FF, 16'h00FF, 1'b1, "after_rst");
    check_eq("after_rst value", 64'(res8), 64'(16'h0001));

    run_op(16, 16'h8000, 16'hFFFF, 1'b1, "w16_signed");
    check_eq("w16_signed value", 64'(res16), 64'(32'h00008000));
    run_op(16, 16'h8000, 16'hFFFF, 1'b0, "w16_unsigned");
    check_eq("w16_unsigned value", 64'(res16), 64'(32'h7FFF8000));

    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rs = 1'($urandom);
      run_op(8, ra, rb, rs, "rand8");
    end
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      run_op(16, ra, rb, rs, "rand16");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplicador_param.md
# multiplicador_param

- Parametrised sequential multiplier for the ULA. Multiplies two WIDTH-bit operands into a 2·WIDTH-bit product, with a per-operation choice of signed (two's-complement) or unsigned mode.
- Iterative shift-add datapath with a start/busy/done handshake; latency is deterministic.
- Operands are captured on start, so the surrounding control logic may change A/B while the operation runs.
- Supersedes the fixed 8-bit signed multiplier.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal values are even and ≥ 4.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; when low, forces every register to its reset value immediately.
- start  in  1  request; sampled high on a clock edge while the block is idle.
- sinal  in  1  mode; 1 = signed two's-complement, 0 = unsigned; captured together with the operands.
- A  in  WIDTH  multiplicand.
- B  in  WIDTH  multiplier.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when RESFINAL is updated.
- RESFINAL  out  2·WIDTH  product; held stable until the next completion.

## Operation
- States: IDLE, CALC, AJUSTE.
- IDLE:
  - busy=0.
  - If start=1 at an edge: latch |A| and |B| into the magnitude registers. Magnitudes are taken from the two's complement when sinal=1 and the MSB is 1; otherwise the raw value.
  - Also latch sign = sinal & (A[MSB] ^ B[MSB]), clear the accumulator and set the counter to 0.
  - Go to CALC.
- CALC, one iteration per cycle:
  - If the multiplier LSB is 1, add the multiplicand magnitude to the upper WIDTH+1 bits of the accumulator.
  - Shift the accumulator/multiplier right by 1.
  - Increment the counter. After WIDTH iterations, go to AJUSTE.
- AJUSTE:
  - RESFINAL ← sign ? −acc : acc, mod 2^(2·WIDTH).
  - done ← 1.
  - Go to IDLE.
- Width rules:
  - A magnitude of −2^(WIDTH−1) is 2^(WIDTH−1) and fits in WIDTH unsigned bits; no overflow occurs.
  - The signed product range [−2^(2W−2)+2^(W−1), 2^(2W−2)] fits in 2·WIDTH bits. The unsigned maximum (2^W−1)² fits.
  - The add carry is held in the extra accumulator bit.
- start while busy=1 is ignored; no queuing.
- A, B and sinal are don't-care outside the accepting edge.
- A zero operand still takes the full latency; there is no early exit.
- done is high only in the cycle after AJUSTE.
- RESFINAL changes only on the AJUSTE→IDLE edge or on reset.

## Timing
- Reset values: RESFINAL=0, done=0, busy=0, state=IDLE, counter=0.
- Reset takes effect asynchronously. Release is sampled on clock.
- Edge E0 accepts start. busy=1 from E0 through E_{WIDTH+1}.
- Edges E1…E_WIDTH perform the iterations.
- Edge E_{WIDTH+1}: RESFINAL valid, done=1, busy=0.
- Latency from the accepting edge to done: WIDTH+1 cycles. For WIDTH=8, done appears 9 cycles after start is sampled.
- done falls on E_{WIDTH+2}.
- Back-to-back operation: start held high in the done cycle is accepted at E_{WIDTH+2}. Throughput is one result per WIDTH+2 cycles.
- reset low mid-operation: the operation is aborted and all outputs go to reset values without waiting for a clock. A start sampled at the first edge after release is accepted normally.
- start high at the same edge that reset is released is accepted.

## Test plan
- WIDTH=8, sinal=1, A=−3 (0xFD), B=7, start pulsed 1 cycle:
  - done exactly 9 cycles after the accepting edge.
  - RESFINAL=0xFFEB (−21); done high 1 cycle; busy high 9 cycles.
- WIDTH=8, sinal=1, A=B=0x80 (−128): RESFINAL=0x4000.
- WIDTH=8, sinal=0, A=B=0xFF: RESFINAL=0xFE01.
- WIDTH=8, sinal=1, A=0x80, B=0x7F: RESFINAL=0xC080 (−16256).
- WIDTH=8, A or B = 0: RESFINAL=0 after the full 9-cycle latency.
- Handshake, WIDTH=8:
  - A=5, B=6 accepted.
  - A/B changed and start pulsed mid-operation: the first result is still 30 (0x001E) and the second start is ignored.
  - start held high through done: the second op is accepted at E10 and done recurs at E19.
- Reset:
  - reset low at iteration 4: busy, done and RESFINAL go to 0 immediately, with no done pulse.
  - After release, A=−1, B=−1 signed: RESFINAL=0x0001.
- WIDTH=16:
  - sinal=1, A=0x8000, B=0xFFFF: RESFINAL=0x00008000, latency 17.
  - sinal=0, same operands: RESFINAL=0x7FFF8000.
